win_shift_reg: RTL and testbench
================================

# win_shift_reg

Parametrised multi-channel tap-window shift register for the convolution datapath. It holds N taps of B bits for each of C channels and shifts in one of three modes per accepted beat: up, down, or inward from both ends. It tracks how many taps hold fresh data and presents a window to the downstream MAC stage with a valid/ready handshake, stalling the upstream when a window is unconsumed. It sits between the pixel line/column fetch logic and the kernel multiply-accumulate array.

## Interface
- `N`, 11: taps per channel; N >= 3.
- `B`, 8: bits per tap.
- `C`, 1: channels; all channels shift in lockstep.
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `clr` in 1: synchronous clear of taps, fill count and pending window.
- `in_valid` in 1: input beat offered.
- `in_ready` out 1: input beat accepted when `in_valid && in_ready`.
- `mode` in 2: `shift_mode_e`, sampled with the beat (HOLD, UP, DOWN, CENTER).
- `din` in C×B: one sample per channel.
- `dout` out C×N×B: tap array; `dout[c][0]` is the LSB end, `dout[c][N-1]` is the MSB end.
- `fill` out $clog2(N+1): fresh-tap count, saturating at N.
- `out_valid` out 1: a complete, unconsumed window is on `dout`.
- `out_ready` in 1: consumer takes the window when `out_valid && out_ready`.

## Operation
- Reset values: `dout` all 0, `fill` 0, `out_valid` 0, `in_ready` 1, last mode = HOLD.
- Accepted beat, per channel:
  - UP: `dout[0]<=din`, `dout[k]<=dout[k-1]` for k=1..N-1.
  - DOWN: `dout[N-1]<=din`, `dout[k]<=dout[k+1]` for k=0..N-2.
  - CENTER: let N2=ceil(N/2). `dout[0]<=din` and `dout[N-1]<=din`. `dout[k]<=dout[k-1]` for k=1..N2-1. `dout[k]<=dout[k+1]` for k=N2..N-2. The centre tap favours the up side. For odd N the old `dout[N2-1]` is discarded.
  - HOLD: the beat is accepted and has no effect on `dout`, `fill` or last mode.
- Fill step: UP and DOWN add 1; CENTER adds 2; the result saturates at N.
  - If the accepted non-HOLD mode differs from the last mode, `fill` restarts at the step (1 or 2), not the sum.
  - The last mode then updates.
- Window pending flag (`out_valid`):
  - Set by an accepted non-HOLD beat whose resulting `fill`==N.
  - Cleared by `out_valid && out_ready` when no such beat is accepted in the same cycle.
  - A simultaneous consume and full-producing accept leaves it set, so a back-to-back window follows.
- `in_ready = !out_valid || out_ready` (combinational). Upstream stalls while a window is unconsumed.
- `clr` has priority over any accept in the same cycle:
  - zeroes `dout`, `fill` and `out_valid`;
  - sets last mode to HOLD;
  - `in_ready` is 1 the next cycle.
- `rstn` assertion mid-operation clears all state immediately, regardless of `clk`.

## Timing
- Single-cycle latency: an accepted beat on edge t is visible on `dout`/`fill` after edge t.
- `out_valid` is registered. It rises in the cycle after the beat that makes `fill` reach N.
- `dout` is stable while `out_valid && !out_ready`, because no beat can be accepted.
- Minimum fill latency from empty: N beats in UP/DOWN, ceil(N/2) beats in CENTER.
- Sustained throughput is 1 beat/cycle with `out_ready` tied high.
- No combinational path from `din`/`mode` to any output. The only combinational path is `out_ready` → `in_ready`.

## Structure
- `win_pkg`:
  - `typedef enum logic [1:0] shift_mode_e {SH_HOLD=0, SH_UP=1, SH_DOWN=2, SH_CENTER=3}`;
  - function `fill_step(mode)`.
- Sub-module `win_lane` (params N, B): one channel's tap array with `shift_en`, `mode`, `clr`, `din`, `dout[N]`. It is instantiated C times in a generate loop.
- The top level holds the fill counter, last-mode register, pending flag and handshake logic.

## Test plan
- N=5, C=2, UP, beats 0x11..0x15 on ch0 (ch1 = ch0+0x80), `out_ready`=1:
  - `out_valid` first high after the 5th beat;
  - ch0 `dout[4:0]` = 11,12,13,14,15;
  - ch1 offset by 0x80.
- Reverse the mode from that full UP window: DOWN beat 0xA0 → `fill`=1, `out_valid`=0, `dout[4]`=A0, `dout[3:0]` = old `dout[4:1]`.
- N=5 CENTER from empty, beats 0x01, 0x02, 0x03:
  - `fill` = 2, 4, 5 (saturates);
  - `out_valid` after beat 3;
  - final `dout[4:0]` = 03,02,01,02,03 (from index 4 down to 0).
- Backpressure with a full window and `out_ready`=0 for 4 cycles with `in_valid`=1:
  - `in_ready`=0 and `dout` unchanged throughout;
  - raising `out_ready` consumes the window and accepts the beat in the same cycle;
  - `out_valid` stays 1.
- HOLD beats interleaved in an UP stream: no change to `dout`, `fill` or last mode, and no restart on the next UP beat.
- `clr` coincident with an accepted beat, and async `rstn` pulsed mid-fill: all outputs return to their reset values; the beat is discarded.

Source files
------------

// File: rtl/win_pkg.sv
// Shared types for the convolution tap-window shift register.
// Shift modes and the fill increment each mode contributes.
package win_pkg;

  typedef enum logic [1:0] {
    SH_HOLD   = 2'd0,
    SH_UP     = 2'd1,
    SH_DOWN   = 2'd2,
    SH_CENTER = 2'd3
  } shift_mode_e;

  function automatic logic [1:0] fill_step(shift_mode_e m);
    case (m)
      SH_UP, SH_DOWN: return 2'd1;
      SH_CENTER:      return 2'd2;
      default:        return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/win_shift_reg_if.sv
// Beat-in / window-out bundle for win_shift_reg.
// master = producer/consumer side, slave = the window register.
interface win_shift_reg_if #(
  parameter int N = 11,
  parameter int B = 8,
  parameter int C = 1
);
  import win_pkg::*;

  localparam int FW = $clog2(N + 1);

  logic                       clr;
  logic                       in_valid;
  logic                       in_ready;
  shift_mode_e                mode;
  logic [C-1:0][B-1:0]        din;
  logic [C-1:0][N-1:0][B-1:0] dout;
  logic [FW-1:0]              fill;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output clr, in_valid, mode, din, out_ready,
    input  in_ready, dout, fill, out_valid
  );

  modport slave (
    input  clr, in_valid, mode, din, out_ready,
    output in_ready, dout, fill, out_valid
  );

endinterface

// File: rtl/win_lane.sv
// One channel's N-tap shift array; shifts up, down or inward.
// The centre tap belongs to the up half, so odd N drops its old value.
module win_lane
  import win_pkg::*;
#(
  parameter int N = 11,
  parameter int B = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clr,
  input  logic                shift_en,
  input  shift_mode_e         mode,
  input  logic [B-1:0]        din,
  output logic [N-1:0][B-1:0] dout
);

  localparam int N2 = (N + 1) / 2;

  logic [N-1:0][B-1:0] nxt;

  always_comb begin
    nxt = dout;
    case (mode)
      SH_UP: begin
        nxt[0] = din;
        for (int k = 1; k < N; k++) nxt[k] = dout[k-1];
      end
      SH_DOWN: begin
        nxt[N-1] = din;
        for (int k = 0; k < N - 1; k++) nxt[k] = dout[k+1];
      end
      SH_CENTER: begin
        for (int k = 1; k < N2; k++) nxt[k] = dout[k-1];
        for (int k = N2; k < N - 1; k++) nxt[k] = dout[k+1];
        nxt[0]   = din;
        nxt[N-1] = din;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         dout <= '0;
    else if (clr)      dout <= '0;
    else if (shift_en) dout <= nxt;
  end

endmodule

// File: rtl/win_shift_reg.sv
// Multi-channel tap-window shift register with fill tracking
// and a valid/ready window handshake toward the MAC array.
module win_shift_reg
  import win_pkg::*;
#(
  parameter int N = 11,
  parameter int B = 8,
  parameter int C = 1
) (
  input logic        clk,
  input logic        rstn,
  win_shift_reg_if.slave bus
);

  localparam int FW = $clog2(N + 1);
  localparam logic [FW:0] NF = (FW + 1)'(N);

  logic [C-1:0][N-1:0][B-1:0] taps;
  logic [FW-1:0] fill_q, fill_d;
  logic [FW:0]   base, sum;
  shift_mode_e   last_q;
  logic          valid_q;
  logic          in_ready;
  logic          shift;

  assign in_ready = !valid_q || bus.out_ready;
  assign shift = bus.in_valid && in_ready && (bus.mode != SH_HOLD);

  // A direction change restarts the count from this beat alone.
  always_comb begin
    base   = (bus.mode == last_q) ? {1'b0, fill_q} : '0;
    sum    = base + {{(FW-1){1'b0}}, fill_step(bus.mode)};
    fill_d = (sum >= NF) ? FW'(N) : sum[FW-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill_q  <= '0;
      last_q  <= SH_HOLD;
      valid_q <= 1'b0;
    end else if (bus.clr) begin
      fill_q  <= '0;
      last_q  <= SH_HOLD;
      valid_q <= 1'b0;
    end else begin
      if (shift) begin
        fill_q <= fill_d;
        last_q <= bus.mode;
      end
      if (shift && fill_d == FW'(N))
        valid_q <= 1'b1;
      else if (valid_q && bus.out_ready)
        valid_q <= 1'b0;
    end
  end

  for (genvar c = 0; c < C; c++) begin : g_lane
    win_lane #(
      .N(N),
      .B(B)
    ) u_lane (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (bus.clr),
      .shift_en(shift),
      .mode    (bus.mode),
      .din     (bus.din[c]),
      .dout    (taps[c])
    );
  end

  assign bus.dout      = taps;
  assign bus.fill      = fill_q;
  assign bus.out_valid = valid_q;
  assign bus.in_ready  = in_ready;

endmodule

// File: tb/tb_win_shift_reg.sv
// Scoreboard bench for win_shift_reg (N=5, C=2).
// Expected windows are queued by stimulus and popped on each consume.
module tb_win_shift_reg;
  import win_pkg::*;

  localparam int N = 5;
  localparam int B = 8;
  localparam int C = 2;

  typedef logic [C-1:0][N-1:0][B-1:0] win_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   tests = 0;
  int   fails = 0;
  win_t exp_q[$];

  always #5 clk = ~clk;

  win_shift_reg_if #(.N(N), .B(B), .C(C)) bus ();

  win_shift_reg #(.N(N), .B(B), .C(C)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ch0 taps from index 4 down to 0; ch1 is ch0 + 0x80
  function automatic win_t mkwin(logic [7:0] a4, logic [7:0] a3,
                                 logic [7:0] a2, logic [7:0] a1,
                                 logic [7:0] a0);
    win_t w;
    logic [N-1:0][B-1:0] v;
    v = {a4, a3, a2, a1, a0};
    w[0] = v;
    for (int k = 0; k < N; k++) w[1][k] = v[k] + 8'h80;
    return w;
  endfunction

  task automatic beat(shift_mode_e m, logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.din[0]   = d;
    bus.din[1]   = d + 8'h80;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.mode     = SH_HOLD;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(string nm);
    chk({nm, "_dout"}, bus.dout, '0);
    chk({nm, "_fill"}, bus.fill, 0);
    chk({nm, "_valid"}, bus.out_valid, 0);
    chk({nm, "_in_ready"}, bus.in_ready, 1);
  endtask

  always @(negedge clk) begin
    win_t e;
    if (rstn && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon_unexpected: got window %0h want none",
                 bus.dout);
      end else begin
        e = exp_q.pop_front();
        chk("mon_window", bus.dout, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  initial begin
    bus.clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mode      = SH_HOLD;
    bus.din       = '0;
    bus.out_ready = 1'b1;
    #12;
    chk_reset("rst");
    rstn = 1'b1;
    idle();

    // UP fill, window after the 5th beat
    for (int i = 0; i < 5; i++) begin
      if (i == 4)
        exp_q.push_back(mkwin(8'h11, 8'h12, 8'h13, 8'h14, 8'h15));
      beat(SH_UP, 8'(8'h11 + i));
      chk("up_fill", bus.fill, i + 1);
      chk("up_valid", bus.out_valid, i == 4);
    end

    // direction reversal restarts the count
    beat(SH_DOWN, 8'hA0);
    chk("down_fill", bus.fill, 1);
    chk("down_valid", bus.out_valid, 0);
    chk("down_dout", bus.dout,
        mkwin(8'hA0, 8'h11, 8'h12, 8'h13, 8'h14));

    bus.clr = 1'b1;
    idle();
    bus.clr = 1'b0;
    chk_reset("clr");

    // CENTER from empty; hold the window with out_ready low
    beat(SH_CENTER, 8'h01);
    chk("ctr_fill1", bus.fill, 2);
    chk("ctr_valid1", bus.out_valid, 0);
    beat(SH_CENTER, 8'h02);
    chk("ctr_fill2", bus.fill, 4);
    chk("ctr_valid2", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    exp_q.push_back(mkwin(8'h03, 8'h02, 8'h01, 8'h02, 8'h03));
    beat(SH_CENTER, 8'h03);
    chk("ctr_fill3", bus.fill, 5);
    chk("ctr_valid3", bus.out_valid, 1);
    chk("ctr_dout", bus.dout,
        mkwin(8'h03, 8'h02, 8'h01, 8'h02, 8'h03));

    bus.in_valid = 1'b1;
    bus.mode     = SH_CENTER;
    bus.din[0]   = 8'h04;
    bus.din[1]   = 8'h84;
    repeat (4) begin
      idle();
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_fill", bus.fill, 5);
      chk("bp_dout", bus.dout,
          mkwin(8'h03, 8'h02, 8'h01, 8'h02, 8'h03));
    end
    exp_q.push_back(mkwin(8'h04, 8'h03, 8'h02, 8'h03, 8'h04));
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.mode     = SH_HOLD;
    chk("b2b_valid", bus.out_valid, 1);
    chk("b2b_fill", bus.fill, 5);
    chk("b2b_dout", bus.dout,
        mkwin(8'h04, 8'h03, 8'h02, 8'h03, 8'h04));
    idle();
    chk("b2b_drained", bus.out_valid, 0);

    // HOLD beats interleaved in an UP stream
    bus.clr = 1'b1;
    idle();
    bus.clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4)
        exp_q.push_back(mkwin(8'h21, 8'h22, 8'h23, 8'h24, 8'h25));
      beat(SH_UP, 8'(8'h21 + i));
      chk("hup_fill", bus.fill, i + 1);
      chk("hup_tap0", bus.dout[0][0], 8'(8'h21 + i));
      if (i < 3) begin
        beat(SH_HOLD, 8'h99);
        chk("hold_fill", bus.fill, i + 1);
        chk("hold_tap0", bus.dout[0][0], 8'(8'h21 + i));
        chk("hold_tap1", bus.dout[1][0], 8'(8'hA1 + i));
        chk("hold_valid", bus.out_valid, 0);
      end
    end
    chk("hup_valid", bus.out_valid, 1);
    idle();

    // clr wins over a coincident accepted beat
    bus.clr = 1'b1;
    idle();
    bus.clr = 1'b0;
    beat(SH_UP, 8'h31);
    beat(SH_UP, 8'h32);
    chk("pre_clr_fill", bus.fill, 2);
    bus.clr = 1'b1;
    beat(SH_UP, 8'h33);
    bus.clr = 1'b0;
    chk_reset("clr_beat");
    beat(SH_UP, 8'h34);
    chk("post_clr_fill", bus.fill, 1);
    chk("post_clr_tap0", bus.dout[0][0], 8'h34);
    chk("post_clr_tap1", bus.dout[0][1], 8'h00);

    // async reset between clock edges
    beat(SH_UP, 8'h35);
    beat(SH_UP, 8'h36);
    chk("pre_rst_fill", bus.fill, 3);
    #1;
    rstn = 1'b0;
    #1;
    chk_reset("async_rst");
    #1;
    rstn = 1'b1;
    beat(SH_UP, 8'h41);
    chk("post_rst_fill", bus.fill, 1);
    chk("post_rst_tap0", bus.dout[0][0], 8'h41);
    chk("post_rst_tap1", bus.dout[0][1], 8'h00);

    idle();
    idle();
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
